// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the nibble index; never below one bit so a single-nibble build still has a counter.
    function automatic int unsigned idx_w(input int unsigned nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit ripple adder slice with carry in/out.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract controller around one shared 4-bit adder.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = idx_w(NIBBLES);
    localparam int unsigned SEL_W   = (WIDTH <= 1) ? 1 : $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SEL_W-1:0]   nib_base;
    logic [NIBBLE_W-1:0] add_a, add_b, add_s;
    logic               add_co;
    logic               last_slice;

    // Slice select: the current nibble of each latched operand feeds the shared adder.
    assign nib_base   = SEL_W'(idx_q) * SEL_W'(NIBBLE_W);
    assign add_a      = opa_q[nib_base +: NIBBLE_W];
    assign add_b      = opb_q[nib_base +: NIBBLE_W];
    assign last_slice = (idx_q == IDX_W'(NIBBLES - 1));

    four_bit_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    // Next-state, datapath updates and result commit.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        work_d  = work_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry with sub.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d[nib_base +: NIBBLE_W] = add_s;
                carry_d = add_co;
                idx_d   = idx_q + IDX_W'(1);
                if (last_slice) begin
                    state_d = DONE;
                    sum_d   = work_d;
                    cout_d  = add_co;
                    ovf_d   = add_co ^ (opa_q[WIDTH-1] ^ opb_q[WIDTH-1] ^ work_d[WIDTH-1]);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, work, carry, index and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=16.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_pass;
    int n_total;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0]   r;
        logic [W-1:0] res;
        logic         c, o;
        if (!s) begin
            r   = {1'b0, x} + {1'b0, y};
            res = r[W-1:0];
            c   = r[W];
            o   = (x[W-1] == y[W-1]) && (res[W-1] != x[W-1]);
        end else begin
            res = x - y;
            c   = (x >= y);
            o   = (x[W-1] != y[W-1]) && (res[W-1] != x[W-1]);
        end
        return {o, c, res};
    endfunction

    // Issue one operation from a negedge; wait (bounded) for done, counting latency and busy cycles.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          output int lat, output int bcnt);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        lat = 0; bcnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
        int lat, bcnt;
        run_op(ta, tb_v, ts, lat, bcnt);
        check({name, "_latency"}, 32'(lat), 32'd5);
        check({name, "_busy_cycles"}, 32'(bcnt), 32'd4);
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        check({name, "_ovf"}, 32'(ovf), 32'(eo));
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [W+1:0] m, m2;
        logic [W-1:0] ra, rb, r1_sum;
        logic         rs;
        int           lat, bcnt, hold_bad, done_seen;

        n_pass = 0; n_total = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                     vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

        // Start during busy ignored; operand toggling during RUN has no effect.
        m = model(16'h1111, 16'h2222, 1'b0);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
        @(negedge clk); start = 1'b1; a = 16'h0F0F;
        @(negedge clk); start = 1'b0;
        lat = 3;
        for (int n = 4; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
        check("ignore_latency", 32'(lat), 32'd5);
        check("ignore_sum", 32'(sum), 32'(m[W-1:0]));
        check("ignore_flags", {30'd0, ovf, cout}, {30'd0, m[W+1], m[W]});
        bcnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (busy || done) bcnt++;
        end
        check("ignore_not_queued", 32'(bcnt), 32'd0);

        // Back-to-back: start in the DONE cycle.
        m  = model(16'h0123, 16'h0456, 1'b0);
        m2 = model(16'h9000, 16'h1234, 1'b1);
        run_op(16'h0123, 16'h0456, 1'b0, lat, bcnt);
        check("b2b_first_latency", 32'(lat), 32'd5);
        check("b2b_first_sum", 32'(sum), 32'(m[W-1:0]));
        r1_sum = sum;
        a = 16'h9000; b = 16'h1234; sub = 1'b1; start = 1'b1;
        lat = 0; hold_bad = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done) begin lat = n; break; end
            if (sum !== r1_sum) hold_bad++;
        end
        check("b2b_second_latency", 32'(lat), 32'd5);
        check("b2b_first_hold", 32'(hold_bad), 32'd0);
        check("b2b_second_sum", 32'(sum), 32'(m2[W-1:0]));
        check("b2b_second_flags", {30'd0, ovf, cout}, {30'd0, m2[W+1], m2[W]});
        @(negedge clk);

        // Reset in the 2nd RUN cycle aborts the operation.
        a = 16'h4444; b = 16'h3333; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        check_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            m = model(ra, rb, rs);
            check_op($sformatf("rand%0d", i), ra, rb, rs, m[W-1:0], m[W], m[W+1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencing controller that performs WIDTH-bit add/subtract using a single shared `four_bit_adder`, one 4-bit slice per clock, least-significant nibble first. It latches operands on a start handshake, steps the adder through every nibble while holding the inter-slice carry in a register, and presents the registered result with a one-cycle done pulse. It is the multi-word arithmetic front end for datapaths built on the 4-bit adder cell, trading latency for area.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 4
- NIBBLES, WIDTH/4, derived local constant; slices per operation

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only while busy=0
- sub  in  1  0: a+b, 1: a-b; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result valid
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; for sub, 1 means no borrow
- ovf  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1: latch a into opa, latch b into opb (b inverted when sub=1), set carry=sub, clear nibble index, go to RUN.
- RUN: busy=1. Drive adder with opa/opb nibble[idx] and carry. Write adder S into work nibble[idx], set carry to adder Cout, increment idx. After the slice with idx=NIBBLES-1, go to DONE.
- DONE: busy=0, done=1 for exactly this cycle. Accept start exactly as in IDLE: go to RUN with newly latched operands, giving back-to-back operation. Otherwise go to IDLE.
- Results are committed on the edge leaving the last RUN cycle:
  - sum = work register, with the final nibble included.
  - cout = final adder Cout.
  - ovf = final Cout XOR carry into bit WIDTH-1.
  - Carry into bit WIDTH-1 = opa[W-1] ^ opb[W-1] ^ sum[W-1].
- sum, cout and ovf hold their values until the next commit. They never show partial results.
- Changes on a, b or sub after acceptance have no effect.
- start while busy=1 is ignored and is not queued.
- Arithmetic is modulo 2^WIDTH. Carry from the last slice appears only on cout.

## Timing
- Reset (async assert, any state, including mid-RUN): state=IDLE; busy, done, sum, cout, ovf all 0; the operation is aborted and no done is issued. The internal carry and idx are cleared.
- Deassertion is synchronous to clk. The first start is accepted on the first rising edge after release.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- start sampled at edge k:
  - busy is high in cycles k+1 through k+NIBBLES.
  - done and the new result appear in cycle k+NIBBLES+1.
  - For WIDTH=16, done is 5 cycles after the accepting edge.
- Throughput: one operation per NIBBLES+1 cycles when start is held or re-asserted in the DONE cycle.
- Critical path: one 4-bit ripple plus the slice mux, independent of WIDTH.

## Structure
- Package `serial_add_pkg` holds:
  - the state typedef (IDLE, RUN, DONE);
  - NIBBLE_W=4;
  - the helper constant for the idx width, $clog2(NIBBLES) with a minimum of 1.
- Exactly one `four_bit_adder` instance, combinational, inside the controller. The slice select is an indexed part-select on opa/opb.
- No other sub-modules. The FSM, idx counter, carry flop, work register and result registers live in `serial_adder_ctrl`.

## Test plan
All scenarios use WIDTH=16.
- Plain add: a=0x1234, b=0x4321, sub=0. Expect sum=0x5555, cout=0, ovf=0. done is high exactly in cycle k+5, and busy is high for 4 cycles.
- Full carry ripple: 0xFFFF+0x0001. Expect sum=0x0000, cout=1, ovf=0. Also 0x7FFF+0x0001. Expect sum=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005-0x0007 gives sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 gives sum=0x7FFF, cout=1, ovf=1.
- Handshake:
  - A start pulse during busy is ignored.
  - a and b are toggled during RUN with no effect on the result.
  - start asserted in the DONE cycle gives a second done exactly 5 cycles later with the correct second result.
  - The first result stays stable until the second commit.
- Reset mid-operation: drop rst_n in the 2nd RUN cycle. Expect all outputs 0 immediately and no done. After release, 0x00FF+0x0001 gives 0x0100 with normal latency.
